hood_mode_ctrl: RTL and testbench
=================================

Name: hood_mode_ctrl

Overview:
- Upstream control stage for the range-hood display path. Debounces the raw front-panel buttons and runs the hood operating-mode state machine.
- Generates the mode, fan level and self-clean indication.
- Produces the remaining minutes/seconds of any timed mode, which the display stage converts into seven-segment data.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive clk cycles a synchronised input must hold a new level before it is accepted
TICK_DIV, 100_000_000, clk cycles per 1 s tick
STORM_SECS, 60, duration of level-3 (storm) run in seconds, range 1..3599
CLEAN_SECS, 180, duration of self-clean in seconds, range 1..3599

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
power_btn  in  1  raw power button, active-high
menu_btn  in  1  raw menu button, active-high
lvl1_btn  in  1  raw level-1 button
lvl2_btn  in  1  raw level-2 button
lvl3_btn  in  1  raw level-3 (storm) button
clean_btn  in  1  raw self-clean button
mode  out  3  0 OFF, 1 STANDBY, 2 MENU, 3 RUN_L1, 4 RUN_L2, 5 RUN_L3, 6 CLEAN, 7 CLEAN_DONE
fan_level  out  2  0 stopped, 1..3 fan speed
clean_done  out  1  high only in CLEAN_DONE
remain_min  out  6  minutes left in timed mode, else 0
remain_sec  out  6  seconds left (0..59) in timed mode, else 0
sec_tick  out  1  one-clk pulse per elapsed second while in a timed mode

Behaviour:
- Reset, applied asynchronously while rst=0:
  - mode=OFF, fan_level=0, clean_done=0, remain_min=0, remain_sec=0, sec_tick=0.
  - Debounced levels=0, tick counter=0.
- Button input path:
  - Each button passes through a 2-flop synchroniser, then a per-button counter.
  - The debounced level changes only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive clks. Any bounce clears the counter.
  - A press pulse lasts one clk, on the 0->1 transition of the debounced level. Release produces nothing.
- Priority when press pulses coincide: power > menu > lvl3 > lvl2 > lvl1 > clean. Only the winner is acted on.
- State changes occur on the clk after the press pulse. All outputs are registered and valid in that same cycle.
- State transitions:
  - OFF: power -> STANDBY. All other buttons ignored.
  - Any state except OFF: power -> OFF. This applies mid-countdown, and the countdown is discarded.
  - STANDBY: menu -> MENU.
  - MENU: lvl1 -> RUN_L1; lvl2 -> RUN_L2; lvl3 -> RUN_L3; clean -> CLEAN; menu -> STANDBY.
  - RUN_L1 / RUN_L2: lvl1 / lvl2 switch between the two levels; menu -> STANDBY; lvl3 -> RUN_L3; clean ignored.
  - RUN_L3: lvl1, lvl2, lvl3 and clean ignored. Menu -> STANDBY. Countdown expiry -> RUN_L2.
  - CLEAN: all buttons except power ignored. Countdown expiry -> CLEAN_DONE.
  - CLEAN_DONE: menu -> STANDBY.
- fan_level by state:
  - OFF, STANDBY, MENU, CLEAN_DONE: 0.
  - RUN_L1: 1.
  - RUN_L2: 2.
  - RUN_L3, CLEAN: 3.
- Timer loading on entry to RUN_L3 or CLEAN:
  - remain_min = N/60 and remain_sec = N%60, with N = STORM_SECS or CLEAN_SECS.
  - The tick counter clears to 0.
- Tick counter:
  - Counts clks only in RUN_L3 and CLEAN.
  - At TICK_DIV-1 it wraps to 0 and sec_tick pulses for 1 clk.
- Countdown on each sec_tick:
  - If remain_sec>0: decrement remain_sec.
  - Else if remain_min>0: remain_min-1 and remain_sec=59.
- Expiry: the transition happens on the tick that takes the count from 0:01 to 0:00, so the first clk of the new state shows 0:00. Total timed duration is exactly N*TICK_DIV clks from the entry cycle.
- On leaving a timed state by any path, remain_min and remain_sec are set to 0 and the tick counter is cleared.
- Re-entering RUN_L3 via MENU reloads the full duration.
- Re-pressing lvl3 while in RUN_L3 is ignored: no reload.
- Reset asserted mid-countdown forces OFF immediately. No state is retained.

Test Plan:
- All benches use DEBOUNCE_CYCLES=4 and TICK_DIV=10.
- Reset: hold rst=0 with arbitrary buttons, then release -> mode=0, fan_level=0, remain=0:00, clean_done=0.
- Debounce: toggle power_btn 1,0,1 at 2-clk intervals, then hold high for 8 clks -> exactly one press.
  - mode goes 0->1 at the first clk after 4 stable synchronised cycles.
  - No change is caused by the bounce.
- Storm, STORM_SECS=3: sequence power, menu, lvl3.
  - Entry -> mode=5, fan=3, 0:03.
  - sec_tick every 10 clks, showing 0:02 then 0:01.
  - At the 30th clk -> mode=4, fan=2, 0:00.
- Clean wrap, CLEAN_SECS=65: sequence power, menu, clean.
  - Entry -> 1:05, then 1:00 after 5 ticks, then 0:59.
  - lvl1 and menu presses are ignored.
  - After 650 clks -> mode=7, clean_done=1, fan=0. A subsequent menu press -> mode=1.
- Simultaneous and abort: in MENU, press lvl1 and lvl3 in the same clk -> mode=5.
  - Power during CLEAN at 0:40 -> mode=0, remain=0:00, sec_tick stays low.
- Reset mid-count: assert rst during RUN_L3 at 0:02 -> all outputs take their reset values asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/hood_mode_ctrl.sv
// Range-hood front-panel control: debounces the raw buttons, runs the operating-mode
// state machine and counts down the storm and self-clean durations for the display stage.
module hood_mode_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TICK_DIV        = 100_000_000,
   parameter int unsigned STORM_SECS      = 60,
   parameter int unsigned CLEAN_SECS      = 180
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power_btn,
   input  logic       menu_btn,
   input  logic       lvl1_btn,
   input  logic       lvl2_btn,
   input  logic       lvl3_btn,
   input  logic       clean_btn,
   output logic [2:0] mode,
   output logic [1:0] fan_level,
   output logic       clean_done,
   output logic [5:0] remain_min,
   output logic [5:0] remain_sec,
   output logic       sec_tick
);

   localparam int unsigned NBTN = 6;
   localparam int BTN_POWER = 0;
   localparam int BTN_MENU  = 1;
   localparam int BTN_LVL3  = 2;
   localparam int BTN_LVL2  = 3;
   localparam int BTN_LVL1  = 4;
   localparam int BTN_CLEAN = 5;

   localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
   localparam logic [5:0] STORM_MIN = 6'(STORM_SECS / 60);
   localparam logic [5:0] STORM_SEC = 6'(STORM_SECS % 60);
   localparam logic [5:0] CLEAN_MIN = 6'(CLEAN_SECS / 60);
   localparam logic [5:0] CLEAN_SEC = 6'(CLEAN_SECS % 60);

   typedef enum logic [2:0] {
      ST_OFF        = 3'd0,
      ST_STANDBY    = 3'd1,
      ST_MENU       = 3'd2,
      ST_RUN_L1     = 3'd3,
      ST_RUN_L2     = 3'd4,
      ST_RUN_L3     = 3'd5,
      ST_CLEAN      = 3'd6,
      ST_CLEAN_DONE = 3'd7
   } state_t;

   logic [NBTN-1:0] btnRaw;
   logic [NBTN-1:0] sync1_q, sync2_q, db_q, press_q;
   logic [DCW-1:0]  dbCnt_q [NBTN];
   logic [NBTN-1:0] win;

   state_t         state_q, state_d;
   logic [5:0]     remMin_q, remMin_d, remSec_q, remSec_d;
   logic [TCW-1:0] tickCnt_q, tickCnt_d;
   logic           secTick_q, secTick_d;
   logic [1:0]     fan_q, fan_d;
   logic           cleanDone_q, cleanDone_d;
   logic           timedNow, tickWrap, lastSec, expTaken;

   assign btnRaw = {clean_btn, lvl1_btn, lvl2_btn, lvl3_btn, menu_btn, power_btn};

   // Synchronise, then accept a new level only after it has held for DEBOUNCE_CYCLES clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         press_q <= '0;
         for (int i = 0; i < NBTN; i++) dbCnt_q[i] <= '0;
      end else begin
         sync1_q <= btnRaw;
         sync2_q <= sync1_q;
         for (int i = 0; i < NBTN; i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i] == db_q[i]) begin
               dbCnt_q[i] <= '0;
            end else if (dbCnt_q[i] == DB_LAST) begin
               dbCnt_q[i] <= '0;
               db_q[i]    <= sync2_q[i];
               press_q[i] <= sync2_q[i];
            end else begin
               dbCnt_q[i] <= dbCnt_q[i] + DCW'(1);
            end
         end
      end
   end

   // Bit order of the button vector is the priority order, so the lowest set press wins.
   always_comb begin
      win = '0;
      for (int i = 0; i < NBTN; i++) begin
         if (press_q[i] && (win == '0)) win[i] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      remMin_d  = remMin_q;
      remSec_d  = remSec_q;
      tickCnt_d = tickCnt_q;
      secTick_d = 1'b0;
      expTaken  = 1'b0;
      timedNow  = (state_q == ST_RUN_L3) || (state_q == ST_CLEAN);
      tickWrap  = timedNow && (tickCnt_q == TICK_LAST);
      lastSec   = (remMin_q == 6'd0) && (remSec_q == 6'd1);

      if (win[BTN_POWER]) begin
         state_d = (state_q == ST_OFF) ? ST_STANDBY : ST_OFF;
      end else begin
         case (state_q)
            ST_STANDBY: if (win[BTN_MENU]) state_d = ST_MENU;
            ST_MENU: begin
               if (win[BTN_MENU])       state_d = ST_STANDBY;
               else if (win[BTN_LVL3])  state_d = ST_RUN_L3;
               else if (win[BTN_LVL2])  state_d = ST_RUN_L2;
               else if (win[BTN_LVL1])  state_d = ST_RUN_L1;
               else if (win[BTN_CLEAN]) state_d = ST_CLEAN;
            end
            ST_RUN_L1, ST_RUN_L2: begin
               if (win[BTN_MENU])      state_d = ST_STANDBY;
               else if (win[BTN_LVL3]) state_d = ST_RUN_L3;
               else if (win[BTN_LVL2]) state_d = ST_RUN_L2;
               else if (win[BTN_LVL1]) state_d = ST_RUN_L1;
            end
            ST_RUN_L3: begin
               if (win[BTN_MENU]) begin
                  state_d = ST_STANDBY;
               end else if (tickWrap && lastSec) begin
                  state_d  = ST_RUN_L2;
                  expTaken = 1'b1;
               end
            end
            ST_CLEAN: begin
               if (tickWrap && lastSec) begin
                  state_d  = ST_CLEAN_DONE;
                  expTaken = 1'b1;
               end
            end
            ST_CLEAN_DONE: if (win[BTN_MENU]) state_d = ST_STANDBY;
            default: state_d = ST_OFF;
         endcase
      end

      // Expiry still counts as an elapsed second; any other exit discards the countdown.
      if ((state_d == ST_RUN_L3) && (state_q != ST_RUN_L3)) begin
         remMin_d  = STORM_MIN;
         remSec_d  = STORM_SEC;
         tickCnt_d = '0;
      end else if ((state_d == ST_CLEAN) && (state_q != ST_CLEAN)) begin
         remMin_d  = CLEAN_MIN;
         remSec_d  = CLEAN_SEC;
         tickCnt_d = '0;
      end else if ((state_d == state_q) && timedNow) begin
         if (tickWrap) begin
            tickCnt_d = '0;
            secTick_d = 1'b1;
            if (remSec_q != 6'd0) begin
               remSec_d = remSec_q - 6'd1;
            end else if (remMin_q != 6'd0) begin
               remMin_d = remMin_q - 6'd1;
               remSec_d = 6'd59;
            end
         end else begin
            tickCnt_d = tickCnt_q + TCW'(1);
         end
      end else begin
         remMin_d  = 6'd0;
         remSec_d  = 6'd0;
         tickCnt_d = '0;
         secTick_d = expTaken;
      end

      case (state_d)
         ST_RUN_L1:          fan_d = 2'd1;
         ST_RUN_L2:          fan_d = 2'd2;
         ST_RUN_L3, ST_CLEAN: fan_d = 2'd3;
         default:            fan_d = 2'd0;
      endcase
      cleanDone_d = (state_d == ST_CLEAN_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_OFF;
         remMin_q    <= '0;
         remSec_q    <= '0;
         tickCnt_q   <= '0;
         secTick_q   <= 1'b0;
         fan_q       <= '0;
         cleanDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remMin_q    <= remMin_d;
         remSec_q    <= remSec_d;
         tickCnt_q   <= tickCnt_d;
         secTick_q   <= secTick_d;
         fan_q       <= fan_d;
         cleanDone_q <= cleanDone_d;
      end
   end

   assign mode       = state_q;
   assign fan_level  = fan_q;
   assign clean_done = cleanDone_q;
   assign remain_min = remMin_q;
   assign remain_sec = remSec_q;
   assign sec_tick   = secTick_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Self-checking bench for hood_mode_ctrl: directed vectors and corner sequences with
// fixed expectations, plus random button traffic compared against a reference model.
module tb_hood_mode_ctrl;

   localparam int TB_DB    = 4;
   localparam int TB_TICK  = 10;
   localparam int TB_STORM = 3;
   localparam int TB_CLEAN = 65;

   localparam logic [5:0] B_PWR  = 6'b000001;
   localparam logic [5:0] B_MENU = 6'b000010;
   localparam logic [5:0] B_L3   = 6'b000100;
   localparam logic [5:0] B_L2   = 6'b001000;
   localparam logic [5:0] B_L1   = 6'b010000;
   localparam logic [5:0] B_CLN  = 6'b100000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] btnVec = '0;
   logic [2:0] mode;
   logic [1:0] fan_level;
   logic       clean_done;
   logic [5:0] remain_min, remain_sec;
   logic       sec_tick;

   int testsRun = 0;
   int testsFailed = 0;
   bit modelEn = 1'b0;

   hood_mode_ctrl #(
      .DEBOUNCE_CYCLES(TB_DB),
      .TICK_DIV(TB_TICK),
      .STORM_SECS(TB_STORM),
      .CLEAN_SECS(TB_CLEAN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .power_btn(btnVec[0]),
      .menu_btn(btnVec[1]),
      .lvl3_btn(btnVec[2]),
      .lvl2_btn(btnVec[3]),
      .lvl1_btn(btnVec[4]),
      .clean_btn(btnVec[5]),
      .mode(mode),
      .fan_level(fan_level),
      .clean_done(clean_done),
      .remain_min(remain_min),
      .remain_sec(remain_sec),
      .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   // Reference model: remaining time kept as total seconds, debounce as a sample window.
   int             mState, mRem, mPh;
   bit             mTick;
   logic [5:0]     mS1, mS2, mDb, mPress, nextPress;
   logic [TB_DB-1:0] mWin [6];
   int             fanOf [8] = '{0, 0, 0, 1, 2, 3, 3, 0};

   task automatic modelFsm();
      int w;
      int ns;
      w = -1;
      for (int i = 0; i < 6; i++) if (w < 0 && mPress[i]) w = i;
      ns = mState;
      if (mState == 0) begin
         if (w == 0) ns = 1;
      end else if (w == 0) begin
         ns = 0;
      end else begin
         case (mState)
            1: if (w == 1) ns = 2;
            2: case (w)
                  1: ns = 1;
                  2: ns = 5;
                  3: ns = 4;
                  4: ns = 3;
                  5: ns = 6;
                  default: ;
               endcase
            3, 4: case (w)
                  1: ns = 1;
                  2: ns = 5;
                  3: ns = 4;
                  4: ns = 3;
                  default: ;
               endcase
            5, 7: if (w == 1) ns = 1;
            default: ;
         endcase
      end
      mTick = 1'b0;
      if (ns != mState) begin
         mRem = (ns == 5) ? TB_STORM : (ns == 6) ? TB_CLEAN : 0;
         mPh = 0;
      end else if (mState == 5 || mState == 6) begin
         if (mPh == TB_TICK - 1) begin
            mPh = 0;
            mRem = mRem - 1;
            mTick = 1'b1;
            if (mRem == 0) ns = (mState == 5) ? 4 : 7;
         end else begin
            mPh = mPh + 1;
         end
      end
      mState = ns;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mState = 0; mRem = 0; mPh = 0; mTick = 1'b0;
         mS1 = '0; mS2 = '0; mDb = '0; mPress = '0;
         for (int b = 0; b < 6; b++) mWin[b] = '0;
      end else begin
         modelFsm();
         nextPress = '0;
         for (int b = 0; b < 6; b++) begin
            mWin[b] = {mWin[b][TB_DB-2:0], mS2[b]};
            if (mWin[b] == {TB_DB{~mDb[b]}}) begin
               mDb[b] = ~mDb[b];
               nextPress[b] = mDb[b];
            end
         end
         mPress = nextPress;
         mS2 = mS1;
         mS1 = btnVec;
      end
   end

   always @(negedge clk) begin
      if (modelEn) begin
         testsRun++;
         if (mode !== 3'(mState) || fan_level !== 2'(fanOf[mState]) ||
             remain_min !== 6'(mRem / 60) || remain_sec !== 6'(mRem % 60) ||
             clean_done !== (mState == 7) || sec_tick !== mTick) begin
            testsFailed++;
            $display("[TB] FAIL model t=%0t got m%0d f%0d %0d:%0d d%0d t%0d exp m%0d f%0d %0d:%0d d%0d t%0d",
                     $time, mode, fan_level, remain_min, remain_sec, clean_done, sec_tick,
                     mState, fanOf[mState], mRem / 60, mRem % 60, mState == 7, mTick);
         end
      end
   end

   task automatic checkOutput(input string name, input int eMode, input int eFan,
                              input int eMin, input int eSec, input int eDone, input int eTick);
      testsRun++;
      if (mode !== 3'(eMode) || fan_level !== 2'(eFan) || remain_min !== 6'(eMin) ||
          remain_sec !== 6'(eSec) || clean_done !== 1'(eDone) || sec_tick !== 1'(eTick)) begin
         testsFailed++;
         $display("[TB] FAIL %s got m%0d f%0d %0d:%0d d%0d t%0d exp m%0d f%0d %0d:%0d d%0d t%0d",
                  name, mode, fan_level, remain_min, remain_sec, clean_done, sec_tick,
                  eMode, eFan, eMin, eSec, eDone, eTick);
      end
   endtask

   // Idle long enough for a prior release to debounce, then hold until the state has moved.
   task automatic applyStimulus(input logic [5:0] btn);
      btnVec = '0;
      repeat (6) @(negedge clk);
      btnVec = btn;
      repeat (7) @(negedge clk);
      btnVec = '0;
   endtask

   typedef struct {
      logic [5:0] btn;
      int eMode;
      int eFan;
      int eMin;
      int eSec;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int r, hold, gap, bit_i;
      bit tickSeen;
      logic [5:0] b;

      vecs[0]  = '{B_MENU,        0, 0, 0, 0};
      vecs[1]  = '{B_L2,          0, 0, 0, 0};
      vecs[2]  = '{B_PWR,         1, 0, 0, 0};
      vecs[3]  = '{B_MENU,        2, 0, 0, 0};
      vecs[4]  = '{B_L1,          3, 1, 0, 0};
      vecs[5]  = '{B_L2,          4, 2, 0, 0};
      vecs[6]  = '{B_CLN,         4, 2, 0, 0};
      vecs[7]  = '{B_L1,          3, 1, 0, 0};
      vecs[8]  = '{B_MENU,        1, 0, 0, 0};
      vecs[9]  = '{B_MENU,        2, 0, 0, 0};
      vecs[10] = '{B_L1 | B_L3,   5, 3, 0, 3};
      vecs[11] = '{B_L3,          5, 3, 0, 2};
      vecs[12] = '{B_L1 | B_L2,   5, 3, 0, 1};
      vecs[13] = '{B_MENU | B_CLN, 1, 0, 0, 0};
      vecs[14] = '{B_PWR | B_MENU, 0, 0, 0, 0};

      // Reset with arbitrary buttons held
      rst = 1'b0;
      repeat (4) begin
         btnVec = 6'($urandom);
         @(negedge clk);
      end
      btnVec = '0;
      rst = 1'b1;
      modelEn = 1'b1;
      @(negedge clk);
      checkOutput("reset", 0, 0, 0, 0, 0, 0);

      // Bouncing power button
      btnVec = B_PWR; repeat (2) @(negedge clk);
      btnVec = '0;    repeat (2) @(negedge clk);
      btnVec = B_PWR; repeat (6) @(negedge clk);
      checkOutput("debounce_early", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("debounce_accept", 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      btnVec = '0;
      repeat (20) @(negedge clk);
      checkOutput("debounce_single", 1, 0, 0, 0, 0, 0);
      applyStimulus(B_PWR);
      checkOutput("to_off", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].btn);
         checkOutput($sformatf("vec%0d", i), vecs[i].eMode, vecs[i].eFan,
                     vecs[i].eMin, vecs[i].eSec, vecs[i].eMode == 7, 0);
      end

      // Storm countdown and expiry to level 2
      applyStimulus(B_PWR);
      applyStimulus(B_MENU);
      applyStimulus(B_L3);
      checkOutput("storm_entry", 5, 3, 0, 3, 0, 0);
      repeat (9) @(negedge clk);
      checkOutput("storm_pre_tick", 5, 3, 0, 3, 0, 0);
      @(negedge clk);
      checkOutput("storm_tick1", 5, 3, 0, 2, 0, 1);
      @(negedge clk);
      checkOutput("storm_tick_low", 5, 3, 0, 2, 0, 0);
      repeat (9) @(negedge clk);
      checkOutput("storm_tick2", 5, 3, 0, 1, 0, 1);
      repeat (9) @(negedge clk);
      checkOutput("storm_last", 5, 3, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("storm_expire", 4, 2, 0, 0, 0, 1);

      // Self-clean across the minute boundary
      applyStimulus(B_PWR);
      applyStimulus(B_PWR);
      applyStimulus(B_MENU);
      applyStimulus(B_CLN);
      checkOutput("clean_entry", 6, 3, 1, 5, 0, 0);
      repeat (50) @(negedge clk);
      checkOutput("clean_1_00", 6, 3, 1, 0, 0, 1);
      repeat (10) @(negedge clk);
      checkOutput("clean_0_59", 6, 3, 0, 59, 0, 1);
      applyStimulus(B_L1);
      checkOutput("clean_ign_lvl1", 6, 3, 0, 58, 0, 0);
      applyStimulus(B_MENU);
      checkOutput("clean_ign_menu", 6, 3, 0, 57, 0, 0);
      repeat (563) @(negedge clk);
      checkOutput("clean_last", 6, 3, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("clean_done", 7, 0, 0, 0, 1, 1);
      applyStimulus(B_MENU);
      checkOutput("clean_done_menu", 1, 0, 0, 0, 0, 0);

      // Power abort in the middle of self-clean
      applyStimulus(B_MENU);
      applyStimulus(B_CLN);
      repeat (242) @(negedge clk);
      checkOutput("abort_pre", 6, 3, 0, 41, 0, 0);
      applyStimulus(B_PWR);
      checkOutput("abort_off", 0, 0, 0, 0, 0, 0);
      tickSeen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (sec_tick !== 1'b0) tickSeen = 1'b1;
      end
      testsRun++;
      if (tickSeen) begin
         testsFailed++;
         $display("[TB] FAIL abort_tick sec_tick got 1 exp 0");
      end

      // Asynchronous reset while storm counts down
      applyStimulus(B_PWR);
      applyStimulus(B_MENU);
      applyStimulus(B_L3);
      repeat (12) @(negedge clk);
      checkOutput("rst_pre", 5, 3, 0, 2, 0, 0);
      #2 rst = 1'b0;
      #1 checkOutput("rst_async", 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_release", 0, 0, 0, 0, 0, 0);

      // Random traffic against the model
      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            b = B_PWR;
         end else if (r < 20) begin
            b = 6'($urandom) & 6'b111110;
         end else begin
            bit_i = $urandom_range(1, 5);
            b = 6'(1 << bit_i);
         end
         hold = $urandom_range(1, 12);
         gap = (r >= 95) ? 100 : $urandom_range(1, 14);
         btnVec = b;
         repeat (hold) @(negedge clk);
         btnVec = '0;
         repeat (gap) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
